// File: rtl/sprite_pixel_fetch.sv
// Maps scan coordinates onto one per-frame-latched sprite, addresses its 1-bit ROM and emits coloured pixels.
// Latency: fixed 3 cycles scan -> pix, one pixel per cycle fully pipelined.
// Backpressure: none; the scan stream never stalls. Optional SPRITE_MIRROR_EN adds the mirror port and horizontal flip.
module sprite_pixel_fetch #(
    parameter int SPR_W  = 147,
    parameter int SPR_H  = 144,
    parameter int ADDR_W = 15,
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int COL_W  = 9,
    parameter logic [COL_W-1:0] COLOUR = 9'h1FF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [X_W-1:0]    pos_x,
    input  logic [Y_W-1:0]    pos_y,
    input  logic              visible,
`ifdef SPRITE_MIRROR_EN
    input  logic              mirror,
`endif
    input  logic              scan_valid,
    input  logic [X_W-1:0]    scan_x,
    input  logic [Y_W-1:0]    scan_y,
    output logic [ADDR_W-1:0] rom_address,
    input  logic              rom_q,
    output logic              pix_valid,
    output logic [X_W-1:0]    pix_x,
    output logic [Y_W-1:0]    pix_y,
    output logic              pix_on,
    output logic [COL_W-1:0]  pix_colour
);

    generate
        if (SPR_W * SPR_H > (1 << ADDR_W)) begin : g_addr_too_small
            $error("sprite_pixel_fetch: SPR_W*SPR_H does not fit in ADDR_W address bits");
        end
    endgenerate

    localparam logic [X_W:0]      SPR_W_X  = (X_W + 1)'(SPR_W);
    localparam logic [Y_W:0]      SPR_H_Y  = (Y_W + 1)'(SPR_H);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(SPR_W);
`ifdef SPRITE_MIRROR_EN
    localparam logic [X_W-1:0]    LAST_COL = X_W'(SPR_W - 1);
`endif

    // Per-frame shadow of the sprite placement
    logic [X_W-1:0]    act_x_q, act_x_d;
    logic [Y_W-1:0]    act_y_q, act_y_d;
    logic              act_vis_q, act_vis_d;
`ifdef SPRITE_MIRROR_EN
    logic              act_mir_q, act_mir_d;
`endif

    // Stage 1
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic              hit_1_q, hit_1_d;
    logic              valid_1_q, valid_1_d;
    logic [X_W-1:0]    x_1_q, x_1_d;
    logic [Y_W-1:0]    y_1_q, y_1_d;

    // Stage 2 (aligned with the ROM read)
    logic              hit_2_q, hit_2_d;
    logic              valid_2_q, valid_2_d;
    logic [X_W-1:0]    x_2_q, x_2_d;
    logic [Y_W-1:0]    y_2_q, y_2_d;

    // Stage 3 outputs
    logic              pix_valid_q, pix_valid_d;
    logic              pix_on_q, pix_on_d;
    logic [COL_W-1:0]  pix_colour_q, pix_colour_d;
    logic [X_W-1:0]    pix_x_q, pix_x_d;
    logic [Y_W-1:0]    pix_y_q, pix_y_d;

    // Stage 0 combinational terms
    logic              in_x, in_y, hit_0;
    logic [X_W-1:0]    col_off, col_eff;
    logic [Y_W-1:0]    row_off;
    logic [ADDR_W-1:0] addr_0;

    // Widened compares so a sprite hanging past the screen edge clips instead of wrapping
    always_comb begin
        in_x    = ({1'b0, scan_x} >= {1'b0, act_x_q}) &&
                  ({1'b0, scan_x} <  ({1'b0, act_x_q} + SPR_W_X));
        in_y    = ({1'b0, scan_y} >= {1'b0, act_y_q}) &&
                  ({1'b0, scan_y} <  ({1'b0, act_y_q} + SPR_H_Y));
        hit_0   = scan_valid & act_vis_q & in_x & in_y;
        col_off = scan_x - act_x_q;
        row_off = scan_y - act_y_q;
`ifdef SPRITE_MIRROR_EN
        col_eff = act_mir_q ? (LAST_COL - col_off) : col_off;
`else
        col_eff = col_off;
`endif
        addr_0  = (ADDR_W'(row_off) * STRIDE) + ADDR_W'(col_eff);
    end

    always_comb begin
        act_x_d   = frame_start ? pos_x   : act_x_q;
        act_y_d   = frame_start ? pos_y   : act_y_q;
        act_vis_d = frame_start ? visible : act_vis_q;
`ifdef SPRITE_MIRROR_EN
        act_mir_d = frame_start ? mirror  : act_mir_q;
`endif

        // Address holds on misses so the ROM sees no needless toggling
        rom_address_d = hit_0 ? addr_0 : rom_address_q;
        hit_1_d       = hit_0;
        valid_1_d     = scan_valid;
        x_1_d         = scan_x;
        y_1_d         = scan_y;

        hit_2_d       = hit_1_q;
        valid_2_d     = valid_1_q;
        x_2_d         = x_1_q;
        y_2_d         = y_1_q;

        pix_valid_d   = valid_2_q;
        pix_on_d      = hit_2_q & rom_q;
        pix_colour_d  = pix_on_d ? COLOUR : '0;
        pix_x_d       = x_2_q;
        pix_y_d       = y_2_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            act_x_q       <= '0;
            act_y_q       <= '0;
            act_vis_q     <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            act_mir_q     <= 1'b0;
`endif
            rom_address_q <= '0;
            hit_1_q       <= 1'b0;
            valid_1_q     <= 1'b0;
            x_1_q         <= '0;
            y_1_q         <= '0;
            hit_2_q       <= 1'b0;
            valid_2_q     <= 1'b0;
            x_2_q         <= '0;
            y_2_q         <= '0;
            pix_valid_q   <= 1'b0;
            pix_on_q      <= 1'b0;
            pix_colour_q  <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
        end else begin
            act_x_q       <= act_x_d;
            act_y_q       <= act_y_d;
            act_vis_q     <= act_vis_d;
`ifdef SPRITE_MIRROR_EN
            act_mir_q     <= act_mir_d;
`endif
            rom_address_q <= rom_address_d;
            hit_1_q       <= hit_1_d;
            valid_1_q     <= valid_1_d;
            x_1_q         <= x_1_d;
            y_1_q         <= y_1_d;
            hit_2_q       <= hit_2_d;
            valid_2_q     <= valid_2_d;
            x_2_q         <= x_2_d;
            y_2_q         <= y_2_d;
            pix_valid_q   <= pix_valid_d;
            pix_on_q      <= pix_on_d;
            pix_colour_q  <= pix_colour_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
        end
    end

    assign rom_address = rom_address_q;
    assign pix_valid   = pix_valid_q;
    assign pix_on      = pix_on_q;
    assign pix_colour  = pix_colour_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch with a registered 1-bit ROM model.
module tb_sprite_pixel_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
    logic        visible;
    logic        mirror;
    logic        scan_valid;
    logic [9:0]  scan_x;
    logic [8:0]  scan_y;
    logic [14:0] rom_address;
    logic        rom_q;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_on;
    logic [8:0]  pix_colour;
    logic        rom_fill;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    // ROM registers the address; contents are a single tb-controlled bit
    always @(posedge clock) rom_q <= rom_fill;

    sprite_pixel_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .visible     (visible),
`ifdef SPRITE_MIRROR_EN
        .mirror      (mirror),
`endif
        .scan_valid  (scan_valid),
        .scan_x      (scan_x),
        .scan_y      (scan_y),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_on      (pix_on),
        .pix_colour  (pix_colour)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic scan(input logic [9:0] x, input logic [8:0] y);
        scan_valid = 1'b1;
        scan_x     = x;
        scan_y     = y;
    endtask

    task automatic idle();
        scan_valid = 1'b0;
    endtask

    task automatic latch(input logic [9:0] x, input logic [8:0] y, input logic vis, input logic mir);
        pos_x = x; pos_y = y; visible = vis; mirror = mir;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        scan(10'd100, 9'd50);
        step();
        checks++; if (pix_valid !== 1'b0) $display("FAIL rst_pix_valid: got %0b want 0", pix_valid); else passed++;
        checks++; if (pix_on !== 1'b0) $display("FAIL rst_pix_on: got %0b want 0", pix_on); else passed++;
        checks++; if (rom_address !== 15'd0) $display("FAIL rst_rom_address: got %0d want 0", rom_address); else passed++;
        checks++; if (pix_colour !== 9'd0) $display("FAIL rst_pix_colour: got %0h want 0", pix_colour); else passed++;
        checks++; if (pix_x !== 10'd0 || pix_y !== 9'd0) $display("FAIL rst_pix_xy: got %0d,%0d want 0,0", pix_x, pix_y); else passed++;
        step();
        checks++; if (pix_valid !== 1'b0) $display("FAIL rst_hold_valid: got %0b want 0", pix_valid); else passed++;
        reset = 1'b0;
        step();
        checks++; if (pix_valid !== 1'b0) $display("FAIL rst_lat1: got %0b want 0", pix_valid); else passed++;
        step();
        checks++; if (pix_valid !== 1'b0) $display("FAIL rst_lat2: got %0b want 0", pix_valid); else passed++;
        step();
        checks++; if (pix_valid !== 1'b1) $display("FAIL rst_lat3_valid: got %0b want 1", pix_valid); else passed++;
        checks++; if (pix_on !== 1'b0) $display("FAIL rst_invisible_on: got %0b want 0", pix_on); else passed++;
        idle();
        step(); step(); step();
    endtask

    task automatic test_basic();
        latch(10'd100, 9'd50, 1'b1, 1'b0);
        scan(10'd100, 9'd50);
        step();
        checks++; if (rom_address !== 15'd0) $display("FAIL basic_addr: got %0d want 0", rom_address); else passed++;
        idle();
        step(); step();
        checks++; if (pix_valid !== 1'b1 || pix_on !== 1'b1) $display("FAIL basic_on: got v=%0b on=%0b want 1,1", pix_valid, pix_on); else passed++;
        checks++; if (pix_x !== 10'd100 || pix_y !== 9'd50) $display("FAIL basic_xy: got %0d,%0d want 100,50", pix_x, pix_y); else passed++;
        checks++; if (pix_colour !== 9'h1FF) $display("FAIL basic_colour: got %0h want 1ff", pix_colour); else passed++;
        // Transparent ROM bit on a hit
        rom_fill = 1'b0;
        scan(10'd101, 9'd50);
        step();
        checks++; if (rom_address !== 15'd1) $display("FAIL transp_addr: got %0d want 1", rom_address); else passed++;
        idle();
        step(); step();
        checks++; if (pix_valid !== 1'b1 || pix_on !== 1'b0 || pix_colour !== 9'd0)
            $display("FAIL transp_pix: got v=%0b on=%0b c=%0h want 1,0,0", pix_valid, pix_on, pix_colour); else passed++;
        rom_fill = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        scan(10'd246, 9'd51);
        step();
        checks++; if (rom_address !== 15'd293) $display("FAIL edge_addr: got %0d want 293", rom_address); else passed++;
        scan(10'd247, 9'd50);
        step();
        checks++; if (rom_address !== 15'd293) $display("FAIL miss_hold_addr: got %0d want 293", rom_address); else passed++;
        idle();
        step();
        checks++; if (pix_on !== 1'b1 || pix_x !== 10'd246 || pix_y !== 9'd51)
            $display("FAIL edge_pix: got on=%0b %0d,%0d want 1 246,51", pix_on, pix_x, pix_y); else passed++;
        step();
        checks++; if (pix_valid !== 1'b1 || pix_on !== 1'b0 || pix_x !== 10'd247 || pix_colour !== 9'd0)
            $display("FAIL right_miss: got v=%0b on=%0b x=%0d c=%0h want 1,0,247,0", pix_valid, pix_on, pix_x, pix_colour); else passed++;
        step();
        checks++; if (pix_valid !== 1'b0) $display("FAIL idle_valid: got %0b want 0", pix_valid); else passed++;
    endtask

    task automatic test_clip();
        latch(10'd600, 9'd50, 1'b1, 1'b0);
        scan(10'd639, 9'd50);
        step();
        checks++; if (rom_address !== 15'd39) $display("FAIL clip_addr: got %0d want 39", rom_address); else passed++;
        scan(10'd0, 9'd50);
        step();
        checks++; if (rom_address !== 15'd39) $display("FAIL nowrap_addr: got %0d want 39", rom_address); else passed++;
        idle();
        step();
        checks++; if (pix_on !== 1'b1 || pix_x !== 10'd639) $display("FAIL clip_pix: got on=%0b x=%0d want 1,639", pix_on, pix_x); else passed++;
        step();
        checks++; if (pix_valid !== 1'b1 || pix_on !== 1'b0 || pix_x !== 10'd0)
            $display("FAIL nowrap_pix: got v=%0b on=%0b x=%0d want 1,0,0", pix_valid, pix_on, pix_x); else passed++;
        step();
    endtask

    task automatic test_shadow();
        latch(10'd100, 9'd50, 1'b1, 1'b0);
        pos_x = 10'd200;
        scan(10'd100, 9'd50);
        step();
        idle();
        step(); step();
        checks++; if (pix_on !== 1'b1) $display("FAIL shadow_hold: got %0b want 1", pix_on); else passed++;
        // Scan in the frame_start cycle still sees the old placement
        frame_start = 1'b1;
        scan(10'd100, 9'd50);
        step();
        frame_start = 1'b0;
        step();
        idle();
        step();
        checks++; if (pix_on !== 1'b1) $display("FAIL same_cycle_old: got %0b want 1", pix_on); else passed++;
        step();
        checks++; if (pix_valid !== 1'b1 || pix_on !== 1'b0) $display("FAIL new_pos_miss: got v=%0b on=%0b want 1,0", pix_valid, pix_on); else passed++;
        latch(10'd100, 9'd50, 1'b0, 1'b0);
        scan(10'd100, 9'd50);
        step();
        idle();
        step(); step();
        checks++; if (pix_valid !== 1'b1 || pix_on !== 1'b0) $display("FAIL invisible: got v=%0b on=%0b want 1,0", pix_valid, pix_on); else passed++;
        step();
    endtask

    task automatic test_reset_midframe();
        latch(10'd100, 9'd50, 1'b1, 1'b0);
        scan(10'd150, 9'd60);
        step();
        checks++; if (rom_address !== 15'd1520) $display("FAIL mid_addr: got %0d want 1520", rom_address); else passed++;
        reset = 1'b1;
        frame_start = 1'b1;
        step();
        reset = 1'b0;
        frame_start = 1'b0;
        checks++; if (rom_address !== 15'd0 || pix_valid !== 1'b0) $display("FAIL mid_reset: got a=%0d v=%0b want 0,0", rom_address, pix_valid); else passed++;
        step();
        step();
        checks++; if (pix_valid !== 1'b0) $display("FAIL mid_dropped: got %0b want 0", pix_valid); else passed++;
        idle();
        step();
        checks++; if (pix_valid !== 1'b1 || pix_on !== 1'b0) $display("FAIL reset_wins: got v=%0b on=%0b want 1,0", pix_valid, pix_on); else passed++;
        checks++; if (rom_address !== 15'd0) $display("FAIL reset_wins_addr: got %0d want 0", rom_address); else passed++;
        step(); step();
    endtask

`ifdef SPRITE_MIRROR_EN
    task automatic test_mirror();
        latch(10'd100, 9'd50, 1'b1, 1'b1);
        scan(10'd100, 9'd50);
        step();
        checks++; if (rom_address !== 15'd146) $display("FAIL mirror_left: got %0d want 146", rom_address); else passed++;
        scan(10'd246, 9'd50);
        step();
        checks++; if (rom_address !== 15'd0) $display("FAIL mirror_right: got %0d want 0", rom_address); else passed++;
        idle();
        step(); step();
    endtask
`endif

    initial begin
        reset = 1'b1; frame_start = 1'b0; pos_x = '0; pos_y = '0; visible = 1'b0; mirror = 1'b0;
        scan_valid = 1'b0; scan_x = '0; scan_y = '0; rom_fill = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_clip();
        test_shadow();
        test_reset_midframe();
`ifdef SPRITE_MIRROR_EN
        test_mirror();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
